// File: rtl/beat_timing_gen.sv
// Beat/phase timing generator feeding the hardwired controller: T1/T2/T3 phases, one-hot W beats.
// Optional single-instruction stepping via STEP input when BEAT_TIMING_STEP_EN is defined.
module beat_timing_gen #(
  parameter int unsigned PHASE_CLKS = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             START,
  input  logic             SHORT,
  input  logic             LONG,
  input  logic             STOP,
`ifdef BEAT_TIMING_STEP_EN
  input  logic             STEP,
`endif
  output logic             T1,
  output logic             T2,
  output logic             T3,
  output logic [3:1]       W,
  output logic             RUNNING,
  output logic [CNT_W-1:0] BEAT_CNT
);

  localparam int unsigned     PS_W    = $clog2(PHASE_CLKS) + 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PHASE_CLKS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_n;
  logic [PS_W-1:0]   ps, ps_n;
  logic              start_q;
  logic              start_rise;
  logic              step_s;
  logic [2:0]        t_n;
  logic [3:1]        w_n, w_adv;
  logic              running_n;
  logic [CNT_W-1:0]  cnt_n;

`ifdef BEAT_TIMING_STEP_EN
  assign step_s = STEP;
`else
  assign step_s = 1'b0;
`endif

  assign start_rise = START & ~start_q;

  // Beat sequencing applied at beat end
  always_comb begin
    w_adv = 3'b001;
    case (W)
      3'b001:  w_adv = SHORT ? 3'b001 : 3'b010;
      3'b010:  w_adv = LONG  ? 3'b100 : 3'b001;
      default: w_adv = 3'b001;
    endcase
  end

  always_comb begin
    state_n   = state;
    ps_n      = ps;
    t_n       = {T3, T2, T1};
    w_n       = W;
    running_n = RUNNING;
    cnt_n     = BEAT_CNT;
    case (state)
      IDLE: begin
        t_n       = 3'b000;
        running_n = 1'b0;
        if (start_rise) begin
          state_n   = RUN;
          t_n       = 3'b001;
          ps_n      = '0;
          running_n = 1'b1;
        end
      end
      RUN: begin
        running_n = 1'b1;
        if (ps != PS_LAST) begin
          ps_n = ps + PS_W'(1);
        end else begin
          ps_n = '0;
          case ({T3, T2, T1})
            3'b001: t_n = 3'b010;
            3'b010: t_n = 3'b100;
            3'b100: begin
              // Final clock of T3: advance beat, count it, maybe halt
              cnt_n = BEAT_CNT + CNT_W'(1);
              w_n   = w_adv;
              if (STOP || (step_s && (w_adv == 3'b001))) begin
                state_n   = IDLE;
                t_n       = 3'b000;
                running_n = 1'b0;
              end else begin
                t_n = 3'b001;
              end
            end
            default: t_n = 3'b001;
          endcase
        end
      end
      default: begin
        state_n   = IDLE;
        t_n       = 3'b000;
        running_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state        <= IDLE;
      ps           <= '0;
      start_q      <= 1'b0;
      {T3, T2, T1} <= 3'b000;
      W            <= 3'b001;
      RUNNING      <= 1'b0;
      BEAT_CNT     <= '0;
    end else begin
      state        <= state_n;
      ps           <= ps_n;
      start_q      <= START;
      {T3, T2, T1} <= t_n;
      W            <= w_n;
      RUNNING      <= running_n;
      BEAT_CNT     <= cnt_n;
    end
  end

endmodule
